// File: rtl/shift_out_transmitter_if.sv
// ============================================================================
// Module   : shift_out_transmitter_if
// Brief    : Word handshake, bit strobe and serial-line bundle for the
//            parallel-to-serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_out_transmitter_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             bit_tick;
  logic             serial_out;
  logic             busy;
  logic             done;

  // Word source and bit-rate generator side.
  modport master (
    output in_valid,
    output in_data,
    output bit_tick,
    input  in_ready,
    input  serial_out,
    input  busy,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  bit_tick,
    output in_ready,
    output serial_out,
    output busy,
    output done
  );
endinterface

`default_nettype wire

// File: rtl/shift_out_transmitter.sv
// ============================================================================
// Module   : shift_out_transmitter
// Brief    : Accepts a WIDTH-bit word over valid/ready and shifts it out one
//            bit per bit_tick, LSB first. A new word can be loaded on the
//            last-bit tick so consecutive words stream with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_out_transmitter #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_VALUE = 1'b1
) (
  input  wire                   clk,
  input  wire                   rst,
  shift_out_transmitter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic w_last;
  logic w_ready;
  logic w_accept;

  // Last-bit tick and the handshake it opens; ready is combinational from bit_tick.
  always_comb begin
    w_last   = (r_state == S_SHIFT) && bus.bit_tick && (r_cnt == C_LAST_IDX);
    w_ready  = (r_state == S_IDLE) || w_last;
    w_accept = bus.in_valid && w_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: any accept (re)enters SHIFT; a last tick without a new word ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last && !w_accept) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register and bit counter; in_data is only captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_sreg <= bus.in_data;
      r_cnt  <= '0;
    end else if (w_last) begin
      r_cnt  <= '0;
    end else if ((r_state == S_SHIFT) && bus.bit_tick) begin
      r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Completion pulse, one cycle after the last-bit tick; reset suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
    end
  end

  // Line is the shift register LSB while shifting, otherwise the idle level.
  always_comb begin
    bus.in_ready   = w_ready;
    bus.busy       = (r_state == S_SHIFT);
    bus.done       = r_done;
    bus.serial_out = (r_state == S_SHIFT) ? r_sreg[0] : IDLE_VALUE;
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_out_transmitter.sv
// ============================================================================
// Module   : tb_shift_out_transmitter
// Brief    : Self-checking bench for shift_out_transmitter: directed vector
//            table, hand-written streaming sequence, randomized traffic
//            against a word/bit-index reference model, and a shift-in
//            loopback receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_out_transmitter;

  localparam int W = 8;

  logic clk;
  logic rst;

  shift_out_transmitter_if #(.WIDTH(W)) bus ();

  shift_out_transmitter #(
    .WIDTH      (W),
    .IDLE_VALUE (1'b1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {rst, valid, data, tick} inputs and expected {ready, serial, busy, done}.
  typedef struct {
    logic         r;
    logic         v;
    logic [W-1:0] d;
    logic         t;
    logic [3:0]   e;
  } vec_t;

  vec_t tab [18];

  int n_vec;
  int n_err;
  int n_done_seen;

  // Reference model: the word on the line and which bit of it is showing.
  logic         m_active;
  logic [W-1:0] m_word;
  int           m_idx;
  logic         m_done;
  logic [W-1:0] m_completed;

  // Loopback shift-in receiver fed from serial_out, enabled on bit_tick.
  logic [W-1:0] rx;
  logic         last_ser;

  task automatic apply(input logic r, input logic v, input logic [W-1:0] d,
                       input logic t, input logic chk, input logic use_tab,
                       input logic [3:0] tab_exp, input string name);
    logic [3:0] got;
    logic [3:0] exp;
    logic       m_ready;
    logic       m_ser;
    logic       m_last;
    logic       m_acc;
    rst             = r;
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.bit_tick    = t;
    #1;
    m_ready  = !m_active || (t && (m_idx == W - 1));
    m_ser    = m_active ? m_word[m_idx] : 1'b1;
    got      = {bus.in_ready, bus.serial_out, bus.busy, bus.done};
    exp      = use_tab ? tab_exp : {m_ready, m_ser, m_active, m_done};
    last_ser = bus.serial_out;
    if (chk) begin
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s t=%0t {ready,serial,busy,done} got=%b required=%b",
                 name, $time, got, exp);
      end
      if (m_done) begin
        n_vec++;
        if (rx !== m_completed) begin
          n_err++;
          $display("FAIL loopback t=%0t received=%h required=%h", $time, rx, m_completed);
        end
      end
      if (bus.done === 1'b1) n_done_seen++;
    end
    @(posedge clk);
    if (t) rx = {last_ser, rx[W-1:1]};
    if (r) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_done   = 1'b0;
    end else begin
      m_last = m_active && t && (m_idx == W - 1);
      m_acc  = v && m_ready;
      m_done = m_last;
      if (m_last) m_completed = m_word;
      if (m_acc) begin
        m_word   = d;
        m_idx    = 0;
        m_active = 1'b1;
      end else if (m_last) begin
        m_active = 1'b0;
      end else if (m_active && t) begin
        m_idx++;
      end
    end
    @(negedge clk);
  endtask

  logic [15:0] stream;

  initial begin
    n_vec       = 0;
    n_err       = 0;
    n_done_seen = 0;
    m_active    = 1'b0;
    m_word      = '0;
    m_idx       = 0;
    m_done      = 1'b0;
    m_completed = '0;
    rx          = '0;
    last_ser    = 1'b1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.bit_tick = 1'b0;

    tab[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b1100}; // idle tick ignored
    tab[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 4'b1100}; // accept A5
    tab[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'b0110}; // bit0=1, latency 1
    tab[3]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 4'b0110}; // valid during shift not taken
    tab[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'b0010}; // bit1=0 held
    tab[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b0010};
    tab[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b0110}; // bit2=1
    tab[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b0010};
    tab[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b0010};
    tab[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b0110}; // bit5=1
    tab[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b0010};
    tab[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b1110}; // last tick: ready comb
    tab[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'b1101}; // done pulse, line idle
    tab[13] = '{1'b0, 1'b1, 8'h3C, 1'b0, 4'b1100}; // accept 3C
    tab[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b0010}; // bit0=0
    tab[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'b0010}; // reset mid-word
    tab[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'b1100}; // idle after first rst edge
    tab[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'b1100}; // released, no done

    @(negedge clk);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'b0, "reset");
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'b0, "reset");

    for (int i = 0; i < 18; i++) begin
      apply(tab[i].r, tab[i].v, tab[i].d, tab[i].t, 1'b1, 1'b1, tab[i].e, "table");
    end

    // Single word A5, one tick every 4 clocks.
    apply(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 4'b0, "slow_load");
    for (int i = 0; i < 4 * W + 4; i++) begin
      apply(1'b0, 1'b0, 8'h00, ((i % 4) == 3), 1'b1, 1'b0, 4'b0, "slow_shift");
    end

    // Back-to-back 0F then F0 with a tick every clock.
    n_done_seen = 0;
    apply(1'b0, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 4'b0, "b2b_load");
    for (int i = 0; i < 2 * W; i++) begin
      apply(1'b0, (i < W), 8'hF0, 1'b1, 1'b1, 1'b0, 4'b0, "b2b_shift");
      stream[i] = last_ser;
    end
    apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0, "b2b_tail");
    apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0, "b2b_tail");
    n_vec++;
    if (stream !== 16'hF00F) begin
      n_err++;
      $display("FAIL b2b_stream got=%h required=%h", stream, 16'hF00F);
    end
    n_vec++;
    if (n_done_seen != 2) begin
      n_err++;
      $display("FAIL b2b_done_count got=%0d required=%0d", n_done_seen, 2);
    end

    // Ticks while idle leave the line alone.
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 4'b1100, "idle_tick");
    end

    // Randomized traffic; occasional resets, mixed tick densities.
    for (int i = 0; i < 3000; i++) begin
      logic         rr;
      logic         vv;
      logic         tt;
      logic [W-1:0] dd;
      rr = ($urandom_range(0, 249) == 0);
      vv = ($urandom_range(0, 2) != 0);
      dd = W'($urandom);
      if (i < 1000)      tt = 1'b1;
      else if (i < 2000) tt = ($urandom_range(0, 1) == 0);
      else               tt = ($urandom_range(0, 4) == 0);
      apply(rr, vv, dd, tt, 1'b1, 1'b0, 4'b0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
